motor_pwm_gen: RTL and testbench

//  Dual-channel motor PWM generator. Consumes the 32-bit left/right duty words

---
 rtl/motor_pwm_gen_pkg.sv | 24 ++
 rtl/motor_pwm_gen_pwm_channel.sv | 54 +++++
 rtl/motor_pwm_gen.sv | 85 ++++++++
 tb/tb_motor_pwm_gen.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/motor_pwm_gen_pkg.sv
// Shared types, default timing constants and the slew-limit helper for the
// dual-channel motor PWM generator.
package motor_pwm_gen_pkg;

    typedef logic [31:0] duty_t;

    localparam int unsigned PWM_PRESC     = 32'd100;
    localparam int unsigned PWM_PERIOD    = 32'd1000;
    localparam int unsigned PWM_RAMP_STEP = 32'd50;

    // Next applied duty: move toward the target by at most step (step 0 = jump).
    function automatic duty_t ramp_next(input duty_t act, input duty_t tgt, input duty_t step);
        duty_t diff;
        diff = (tgt > act) ? (tgt - act) : (act - tgt);
        if ((step == 32'd0) || (diff <= step)) begin
            return tgt;
        end else if (tgt > act) begin
            return act + step;
        end else begin
            return act - step;
        end
    endfunction

endpackage

// File: rtl/motor_pwm_gen_pwm_channel.sv
// One PWM channel: clamps the target duty, slews the applied duty at period
// boundaries and compares it against the shared period counter.
module pwm_channel
    import motor_pwm_gen_pkg::*;
#(
    parameter int unsigned PERIOD    = PWM_PERIOD,
    parameter int unsigned RAMP_STEP = PWM_RAMP_STEP
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        bnd,
    input  logic [31:0] cnt,
    input  logic [31:0] duty,
    output logic        pwm_out,
    output logic [31:0] duty_act
);

    localparam duty_t PERIOD_C = duty_t'(PERIOD);
    localparam duty_t STEP_C   = duty_t'(RAMP_STEP);

    duty_t tgt_s;
    duty_t act_nxt_s;
    duty_t act_r;
    logic  pwm_r;

    // Clamp the target and pick the next applied duty; disable overrides a boundary.
    always_comb begin
        tgt_s     = (duty > PERIOD_C) ? PERIOD_C : duty;
        act_nxt_s = act_r;
        if (!en) begin
            act_nxt_s = 32'd0;
        end else if (bnd) begin
            act_nxt_s = ramp_next(act_r, tgt_s, STEP_C);
        end else begin
            act_nxt_s = act_r;
        end
    end

    // Applied-duty register and registered compare output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act_r <= 32'd0;
            pwm_r <= 1'b0;
        end else begin
            act_r <= act_nxt_s;
            pwm_r <= en && (cnt < act_r);
        end
    end

    assign pwm_out  = pwm_r;
    assign duty_act = act_r;

endmodule

// File: rtl/motor_pwm_gen.sv
// Dual-channel motor PWM generator: shared prescaled timebase and period
// strobe feeding a left and a right pwm_channel.
module motor_pwm_gen
    import motor_pwm_gen_pkg::*;
#(
    parameter int unsigned PRESC     = PWM_PRESC,
    parameter int unsigned PERIOD    = PWM_PERIOD,
    parameter int unsigned RAMP_STEP = PWM_RAMP_STEP
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [31:0] duty_l,
    input  logic [31:0] duty_r,
    output logic        pwm_out_l,
    output logic        pwm_out_r,
    output logic [31:0] duty_l_act,
    output logic [31:0] duty_r_act,
    output logic        period_stb
);

    localparam duty_t PRESC_LAST_C  = duty_t'(PRESC - 32'd1);
    localparam duty_t PERIOD_LAST_C = duty_t'(PERIOD - 32'd1);

    duty_t pcnt_r;
    duty_t cnt_r;
    logic  stb_r;
    logic  tick_s;
    logic  bnd_s;

    // Tick and boundary decode from the current counter values.
    always_comb begin
        tick_s = (pcnt_r == PRESC_LAST_C);
        bnd_s  = tick_s && (cnt_r == PERIOD_LAST_C);
    end

    // Prescaler, period counter and registered period strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcnt_r <= 32'd0;
            cnt_r  <= 32'd0;
            stb_r  <= 1'b0;
        end else begin
            stb_r <= bnd_s;
            if (tick_s) begin
                pcnt_r <= 32'd0;
                cnt_r  <= (cnt_r == PERIOD_LAST_C) ? 32'd0 : (cnt_r + 32'd1);
            end else begin
                pcnt_r <= pcnt_r + 32'd1;
                cnt_r  <= cnt_r;
            end
        end
    end

    assign period_stb = stb_r;

    pwm_channel #(
        .PERIOD    (PERIOD),
        .RAMP_STEP (RAMP_STEP)
    ) u_chan_l (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .bnd      (bnd_s),
        .cnt      (cnt_r),
        .duty     (duty_l),
        .pwm_out  (pwm_out_l),
        .duty_act (duty_l_act)
    );

    pwm_channel #(
        .PERIOD    (PERIOD),
        .RAMP_STEP (RAMP_STEP)
    ) u_chan_r (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .bnd      (bnd_s),
        .cnt      (cnt_r),
        .duty     (duty_r),
        .pwm_out  (pwm_out_r),
        .duty_act (duty_r_act)
    );

endmodule

// File: tb/tb_motor_pwm_gen.sv
// Directed bench for motor_pwm_gen: an unlimited-slew instance (u_dut0) and a
// slew-limited instance (u_dut1) share clock, reset, enable and duty inputs.
module tb_motor_pwm_gen;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic [31:0] duty_l = 32'd0;
    logic [31:0] duty_r = 32'd0;

    logic        pwm_l0, pwm_r0, stb0;
    logic [31:0] act_l0, act_r0;
    logic        pwm_l1, pwm_r1, stb1;
    logic [31:0] act_l1, act_r1;

    int vectors = 0;
    int miscompares = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    motor_pwm_gen #(.PRESC(1), .PERIOD(10), .RAMP_STEP(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .en(en), .duty_l(duty_l), .duty_r(duty_r),
        .pwm_out_l(pwm_l0), .pwm_out_r(pwm_r0), .duty_l_act(act_l0),
        .duty_r_act(act_r0), .period_stb(stb0)
    );

    motor_pwm_gen #(.PRESC(1), .PERIOD(10), .RAMP_STEP(2)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .en(en), .duty_l(duty_l), .duty_r(duty_r),
        .pwm_out_l(pwm_l1), .pwm_out_r(pwm_r1), .duty_l_act(act_l1),
        .duty_r_act(act_r1), .period_stb(stb1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // Advance to the next negedge on which period_stb is high; returns clocks taken.
    task automatic wait_stb(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!stb0 && (n < 40));
        chk("stb_seen", {31'd0, stb0}, 32'd1);
    endtask

    // Count high clocks of left PWM (u_dut0) over one full period, optional mid-period duty change.
    task automatic measure(input int chg_at, input logic [31:0] chg_val, output int highs);
        highs = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (pwm_l0) highs++;
            if (i == chg_at) duty_l = chg_val;
        end
        chk("stb_every_10", {31'd0, stb0}, 32'd1);
    endtask

    task automatic measure_pop(input int chg_at, input logic [31:0] chg_val, input string tag);
        int h;
        logic [31:0] e;
        measure(chg_at, chg_val, h);
        e = exp_q.pop_front();
        chk(tag, 32'(h), e);
    endtask

    task automatic ramp_pop(input string tag);
        int n;
        logic [31:0] e;
        wait_stb(n);
        e = exp_q.pop_front();
        chk(tag, act_r1, e);
    endtask

    initial begin
        int n;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_pwm_l", {31'd0, pwm_l0}, 32'd0);
        chk("rst_pwm_r", {31'd0, pwm_r1}, 32'd0);
        chk("rst_stb", {31'd0, stb0}, 32'd0);
        chk("rst_act_l", act_l0, 32'd0);
        chk("rst_act_r", act_r1, 32'd0);
        rst_n = 1'b1;
        wait_stb(n);
        chk("first_stb_lat", 32'(n), 32'd10);

        // Duty 3, no slew
        en = 1'b1;
        duty_l = 32'd3;
        wait_stb(n);
        chk("stb_period", 32'(n), 32'd10);
        chk("act_l_3", act_l0, 32'd3);
        exp_q.push_back(32'd3);
        exp_q.push_back(32'd3);
        measure_pop(-1, 32'd0, "high_3_a");
        measure_pop(-1, 32'd0, "high_3_b");

        // Mid-period change 3 -> 6 at cnt=4
        exp_q.push_back(32'd3);
        exp_q.push_back(32'd6);
        measure_pop(3, 32'd6, "mid_chg_cur");
        measure_pop(-1, 32'd0, "mid_chg_next");
        chk("act_l_6", act_l0, 32'd6);

        // Boundary duties 0, 10, all-ones
        duty_l = 32'd0;
        exp_q.push_back(32'd6);
        exp_q.push_back(32'd0);
        measure_pop(-1, 32'd0, "d0_prev");
        measure_pop(-1, 32'd0, "d0_low");
        duty_l = 32'd10;
        exp_q.push_back(32'd0);
        exp_q.push_back(32'd10);
        exp_q.push_back(32'd10);
        measure_pop(-1, 32'd0, "d10_prev");
        measure_pop(-1, 32'd0, "d10_high_a");
        measure_pop(-1, 32'd0, "d10_high_b");
        chk("act_l_10", act_l0, 32'd10);
        duty_l = 32'hFFFF_FFFF;
        exp_q.push_back(32'd10);
        exp_q.push_back(32'd10);
        measure_pop(-1, 32'd0, "dmax_high_a");
        measure_pop(-1, 32'd0, "dmax_high_b");
        chk("act_l_clamp", act_l0, 32'd10);

        // Slew-limited ramp up and down on the right channel
        duty_r = 32'd9;
        exp_q.push_back(32'd2); exp_q.push_back(32'd4); exp_q.push_back(32'd6);
        exp_q.push_back(32'd8); exp_q.push_back(32'd9); exp_q.push_back(32'd9);
        for (int i = 0; i < 6; i++) ramp_pop("ramp_up");
        duty_r = 32'd0;
        exp_q.push_back(32'd7); exp_q.push_back(32'd5); exp_q.push_back(32'd3);
        exp_q.push_back(32'd1); exp_q.push_back(32'd0); exp_q.push_back(32'd0);
        for (int i = 0; i < 6; i++) ramp_pop("ramp_down");

        // Enable dropped mid-period
        duty_r = 32'd9;
        exp_q.push_back(32'd2);
        exp_q.push_back(32'd4);
        ramp_pop("pre_dis_ramp");
        ramp_pop("pre_dis_ramp");
        repeat (4) @(negedge clk);
        chk("pre_dis_pwm_r", {31'd0, pwm_r1}, 32'd1);
        chk("pre_dis_pwm_l", {31'd0, pwm_l0}, 32'd1);
        en = 1'b0;
        @(negedge clk);
        chk("dis_pwm_r", {31'd0, pwm_r1}, 32'd0);
        chk("dis_pwm_l", {31'd0, pwm_l0}, 32'd0);
        chk("dis_act_r", act_r1, 32'd0);
        chk("dis_act_l", act_l0, 32'd0);
        wait_stb(n);
        chk("dis_cnt_runs", 32'(n), 32'd5);
        chk("dis_act_hold0", act_r1, 32'd0);
        en = 1'b1;
        exp_q.push_back(32'd2);
        exp_q.push_back(32'd4);
        ramp_pop("reen_ramp");
        ramp_pop("reen_ramp");

        // Enable dropped on the boundary clock
        repeat (9) @(negedge clk);
        chk("pre_bnd_act_r", act_r1, 32'd4);
        en = 1'b0;
        @(negedge clk);
        chk("bnd_dis_stb", {31'd0, stb0}, 32'd1);
        chk("bnd_dis_act_r", act_r1, 32'd0);
        en = 1'b1;
        exp_q.push_back(32'd2);
        ramp_pop("post_bnd_ramp");

        // Async reset at cnt=5
        chk("pre_rst_act_l", act_l0, 32'd10);
        repeat (5) @(negedge clk);
        chk("pre_rst_pwm_l", {31'd0, pwm_l0}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_async_pwm_l", {31'd0, pwm_l0}, 32'd0);
        chk("rst_async_act_l", act_l0, 32'd0);
        chk("rst_async_act_r", act_r1, 32'd0);
        chk("rst_async_stb", {31'd0, stb0}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_stb(n);
        chk("rst_restart_lat", 32'(n), 32'd10);
        chk("rst_restart_stb1", {31'd0, stb1}, 32'd1);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
